core_biu: RTL and testbench
===========================

# core_biu

Parametrised bus interface unit: merges NUM_MASTERS core-side memory request channels (port 0 = IFU fetch, port 1 = LSU, further ports reserved) onto a single memory interface. Supports multiple outstanding transactions and routes in-order responses back to the issuing master. Sits inside the core top level, between the IFU/LSU request ports and the external memory port. Replaces the separate per-unit memory ports.

## Interface
Parameters:
- NUM_MASTERS, 2, number of request channels (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask is DATA_W/8
- OUTS_DEPTH, 4, max outstanding transactions; power of two, ≥2

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- m_cmd_valid  in  NUM_MASTERS  per-master command valid
- m_cmd_ready  out  NUM_MASTERS  per-master command accept
- m_cmd_addr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- m_cmd_read  in  NUM_MASTERS  1 = read, 0 = write
- m_cmd_wdata  in  NUM_MASTERS*DATA_W  packed write data
- m_cmd_wmask  in  NUM_MASTERS*DATA_W/8  packed byte enables
- m_rsp_valid  out  NUM_MASTERS  per-master response valid
- m_rsp_ready  in  NUM_MASTERS  per-master response accept
- m_rsp_rdata  out  DATA_W  response data, shared by all masters
- m_rsp_err  out  1  response error, shared by all masters
- s_cmd_valid / s_cmd_ready  out / in  1  memory-side command handshake
- s_cmd_addr, s_cmd_read, s_cmd_wdata, s_cmd_wmask  out  ADDR_W, 1, DATA_W, DATA_W/8  granted command fields
- s_rsp_valid / s_rsp_ready  in / out  1  memory-side response handshake
- s_rsp_rdata, s_rsp_err  in  DATA_W, 1  response payload
- outs_cnt  out  $clog2(OUTS_DEPTH)+1  outstanding transaction count
- err_unexp_rsp  out  1  sticky: s_rsp_valid seen while nothing outstanding

## Operation
- Handshake rule: a transfer occurs on any cycle where valid && ready are both high.
- Arbitration:
  - Candidates: masters with m_cmd_valid high.
  - Issue is allowed only when outs_cnt < OUTS_DEPTH.
  - s_cmd_valid = (any candidate) && !full.
  - s_cmd_* fields are muxed from the granted master.
  - m_cmd_ready[g] = s_cmd_ready && s_cmd_valid, for the granted g only. All other masters see m_cmd_ready = 0.
- Grant lock:
  - If s_cmd_valid is high and s_cmd_ready is low, the grant is registered and held until that command handshakes.
  - Higher-priority arrivals do not preempt a locked grant.
- Tracking:
  - On each cmd handshake, the granted index is pushed into an OUTS_DEPTH-entry ID FIFO.
  - On each s_rsp handshake, the ID FIFO is popped.
  - outs_cnt = FIFO occupancy.
- Response routing:
  - The head ID h selects the destination: m_rsp_valid[h] = s_rsp_valid && !empty.
  - s_rsp_ready = m_rsp_ready[h] && !empty.
  - m_rsp_rdata and m_rsp_err pass through unchanged.
- Full:
  - s_cmd_valid is forced to 0 whenever the FIFO is full, even if a pop occurs in the same cycle.
  - Issue resumes the cycle after occupancy drops.
- Empty:
  - s_rsp_ready = 0 and all m_rsp_valid = 0.
  - If s_rsp_valid is high while empty, err_unexp_rsp is set next cycle and stays set until rst.
- Simultaneous push and pop (not full) leaves outs_cnt unchanged.
- FIFO read/write pointers wrap modulo OUTS_DEPTH.

## Timing
- Zero-cycle combinational paths for both cmd and rsp; no added latency.
- FIFO, outs_cnt, grant lock, RR pointer and err_unexp_rsp update at the clock edge following their event.
- Reset state:
  - FIFO empty, outs_cnt = 0, lock clear, RR pointer = 0, err_unexp_rsp = 0.
  - With all inputs idle, every output is 0.
- Reset mid-operation:
  - All outstanding IDs are discarded.
  - Responses arriving after reset count as unexpected.
- Back-to-back issue: one command per cycle when s_cmd_ready stays high and the FIFO is not full.

## Configuration
- CORE_BIU_RR_ARB_EN:
  - Defined: round-robin arbitration. The pointer advances to (granted index + 1) mod NUM_MASTERS after each cmd handshake, and the search starts from the pointer.
  - Undefined: fixed priority, lowest index wins; the RR pointer logic is absent.
  - Grant lock applies in both modes.

## Test plan
- IFU and LSU both request addr 0x8000_0000 and 0x8000_0100 with s_cmd_ready=1:
  - Fixed mode: IFU issued in cycle 0, LSU in cycle 1.
  - RR mode, after an IFU grant: the next simultaneous request goes to the LSU.
- LSU request with s_cmd_ready=0 for 3 cycles, IFU raises valid in cycle 1:
  - LSU grant held until its handshake in cycle 3.
  - IFU then issues in cycle 4.
- Issue 4 reads with OUTS_DEPTH=4 and no responses:
  - outs_cnt=4 and s_cmd_valid=0 while IFU keeps valid high.
  - After one s_rsp handshake, outs_cnt=3 and issue resumes the next cycle.
- Interleaved IFU, LSU, IFU commands, then 3 responses with rdata 0x11, 0x22, 0x33:
  - Delivered to IFU, LSU, IFU in that order.
  - While m_rsp_ready=0 at the head master, s_rsp_ready=0.
- s_rsp_valid=1 with outs_cnt=0:
  - err_unexp_rsp=1 next cycle, held through later traffic.
  - Cleared only by rst.
- Assert rst with 2 outstanding transactions:
  - Next cycle outs_cnt=0 and all m_rsp_valid=0.
  - A new command is accepted immediately after rst deasserts.

Source files
------------

// File: rtl/core_biu.sv
// core_biu - bus interface unit for the core.
//
// Merges NUM_MASTERS request channels (0 = IFU fetch, 1 = LSU, others
// reserved) onto one memory port. Several transactions may be in flight.
// The memory returns responses in order, and each response goes back to the
// master that issued the matching command.
//
// Configuration macro: CORE_BIU_RR_ARB_EN
//   defined   -> round-robin arbitration; the search starts at a pointer that
//                moves past the last master served
//   undefined -> fixed priority; the lowest index wins
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   m_cmd_valid/ready              per-master command handshake
//   m_cmd_addr/read/wdata/wmask    packed per-master command fields
//   m_rsp_valid/ready              per-master response handshake
//   m_rsp_rdata, m_rsp_err         response payload, shared by all masters
//   s_cmd_*                        memory-side command (granted master)
//   s_rsp_*                        memory-side response
//   outs_cnt                       number of outstanding transactions
//   err_unexp_rsp                  sticky flag: response arrived with nothing
//                                  outstanding
module core_biu #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTS_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_cmd_valid,
  output logic [NUM_MASTERS-1:0]        m_cmd_ready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_cmd_addr,
  input  logic [NUM_MASTERS-1:0]        m_cmd_read,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_cmd_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_cmd_wmask,
  output logic [NUM_MASTERS-1:0]        m_rsp_valid,
  input  logic [NUM_MASTERS-1:0]        m_rsp_ready,
  output logic [DATA_W-1:0]             m_rsp_rdata,
  output logic                          m_rsp_err,
  output logic                          s_cmd_valid,
  input  logic                          s_cmd_ready,
  output logic [ADDR_W-1:0]             s_cmd_addr,
  output logic                          s_cmd_read,
  output logic [DATA_W-1:0]             s_cmd_wdata,
  output logic [DATA_W/8-1:0]           s_cmd_wmask,
  input  logic                          s_rsp_valid,
  output logic                          s_rsp_ready,
  input  logic [DATA_W-1:0]             s_rsp_rdata,
  input  logic                          s_rsp_err,
  output logic [$clog2(OUTS_DEPTH):0]   outs_cnt,
  output logic                          err_unexp_rsp
);

  localparam int MASK_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PTR_W  = $clog2(OUTS_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [IDX_W-1:0] id_fifo [OUTS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx;
  logic             err_q;

  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] head;
  logic             gnt_valid;
  logic             head_ready;
  logic             full;
  logic             empty;
  logic             cmd_push;
  logic             rsp_pop;

`ifdef CORE_BIU_RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr;
  logic             hi_found;
  logic [IDX_W-1:0] hi_idx;
`endif

  assign full     = (count == CNT_W'(OUTS_DEPTH));
  assign empty    = (count == '0);
  assign head     = id_fifo[rd_ptr];
  assign cmd_push = s_cmd_valid && s_cmd_ready;
  assign rsp_pop  = s_rsp_valid && s_rsp_ready;

  assign outs_cnt      = count;
  assign err_unexp_rsp = err_q;
  assign m_rsp_rdata   = s_rsp_rdata;
  assign m_rsp_err     = s_rsp_err;

  // Choose a master from the current requests. Round-robin takes the lowest
  // requester at or above the pointer and wraps to the lowest requester
  // overall when there is none. Fixed priority takes the lowest requester.
  always_comb begin
    arb_idx = '0;
`ifdef CORE_BIU_RR_ARB_EN
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_cmd_valid[i]) begin
        arb_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    if (hi_found) begin
      arb_idx = hi_idx;
    end
`else
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_cmd_valid[i]) begin
        arb_idx = IDX_W'(i);
      end
    end
`endif
  end

  // A stalled command keeps its grant, so a later higher-priority request
  // cannot change the fields while the memory side is still looking at them.
  assign gnt = lock_q ? lock_idx : arb_idx;

  // Route the granted master's fields to the memory port. Only the granted
  // master sees ready. Issue is blocked while the ID FIFO is full.
  always_comb begin
    s_cmd_addr  = '0;
    s_cmd_read  = 1'b0;
    s_cmd_wdata = '0;
    s_cmd_wmask = '0;
    gnt_valid   = 1'b0;
    m_cmd_ready = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt == IDX_W'(i)) begin
        s_cmd_addr  = m_cmd_addr[i*ADDR_W +: ADDR_W];
        s_cmd_read  = m_cmd_read[i];
        s_cmd_wdata = m_cmd_wdata[i*DATA_W +: DATA_W];
        s_cmd_wmask = m_cmd_wmask[i*MASK_W +: MASK_W];
        gnt_valid   = m_cmd_valid[i];
      end
    end
    s_cmd_valid = gnt_valid && !full;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_cmd_ready[i] = s_cmd_valid && s_cmd_ready && (gnt == IDX_W'(i));
    end
  end

  // The oldest outstanding ID selects which master gets the response.
  // Nothing is routed while the FIFO is empty.
  always_comb begin
    head_ready  = 1'b0;
    m_rsp_valid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (head == IDX_W'(i)) begin
        head_ready     = m_rsp_ready[i];
        m_rsp_valid[i] = s_rsp_valid && !empty;
      end
    end
  end

  assign s_rsp_ready = head_ready && !empty;

  // Sequential state: ID FIFO, occupancy, grant lock, error flag and the
  // round-robin pointer. The pointers wrap naturally because OUTS_DEPTH is a
  // power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        id_fifo[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lock_q   <= 1'b0;
      lock_idx <= '0;
      err_q    <= 1'b0;
`ifdef CORE_BIU_RR_ARB_EN
      rr_ptr   <= '0;
`endif
    end else begin
      if (cmd_push) begin
        id_fifo[wr_ptr] <= gnt;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (rsp_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({cmd_push, rsp_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      lock_q <= s_cmd_valid && !s_cmd_ready;
      if (s_cmd_valid && !s_cmd_ready) begin
        lock_idx <= gnt;
      end
      if (s_rsp_valid && empty) begin
        err_q <= 1'b1;
      end
`ifdef CORE_BIU_RR_ARB_EN
      if (cmd_push) begin
        rr_ptr <= (gnt == IDX_W'(NUM_MASTERS - 1)) ? '0 : gnt + IDX_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_core_biu.sv
// tb_core_biu - randomized scoreboard bench for core_biu.
//
// Random masters and a random in-order memory model drive the DUT. A
// reference model predicts the cycle-level command and response handshakes.
// It keeps a queue of outstanding master IDs and computes the grant from the
// arbitration rules. Each issued command pushes its expected response into a
// scoreboard. A separate monitor pops that scoreboard whenever a master
// accepts a response.
module tb_core_biu;

  localparam int NM    = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic [NM-1:0]     m_cmd_valid;
  logic [NM-1:0]     m_cmd_ready;
  logic [NM*AW-1:0]  m_cmd_addr;
  logic [NM-1:0]     m_cmd_read;
  logic [NM*DW-1:0]  m_cmd_wdata;
  logic [NM*MW-1:0]  m_cmd_wmask;
  logic [NM-1:0]     m_rsp_valid;
  logic [NM-1:0]     m_rsp_ready;
  logic [DW-1:0]     m_rsp_rdata;
  logic              m_rsp_err;
  logic              s_cmd_valid;
  logic              s_cmd_ready;
  logic [AW-1:0]     s_cmd_addr;
  logic              s_cmd_read;
  logic [DW-1:0]     s_cmd_wdata;
  logic [MW-1:0]     s_cmd_wmask;
  logic              s_rsp_valid;
  logic              s_rsp_ready;
  logic [DW-1:0]     s_rsp_rdata;
  logic              s_rsp_err;
  logic [CW-1:0]     outs_cnt;
  logic              err_unexp_rsp;

  core_biu #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .OUTS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_addr(m_cmd_addr), .m_cmd_read(m_cmd_read),
    .m_cmd_wdata(m_cmd_wdata), .m_cmd_wmask(m_cmd_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_read(s_cmd_read),
    .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
    .outs_cnt(outs_cnt), .err_unexp_rsp(err_unexp_rsp)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  int tests = 0;
  int fails = 0;

  // Pending master commands. Each master holds its command until it is accepted.
  logic [AW-1:0] p_addr  [NM];
  logic          p_read  [NM];
  logic [DW-1:0] p_wdata [NM];
  logic [MW-1:0] p_wmask [NM];
  bit            pend    [NM];

  // Memory model: in-order queue of accepted addresses.
  logic [AW-1:0] slave_q[$];
  bit            sl_valid;

  // Reference model state and scoreboard.
  int   mq[$];
  bit   m_lock;
  int   m_lock_id;
  int   m_rr;
  bit   m_err;
  exp_t sb[$];

  // Stimulus knobs (percent probabilities).
  int p_valid, p_sready, p_rsp, p_mready;
  bit quiet, force_unexp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rsp_data(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic rsp_err(input logic [AW-1:0] a);
    return a[3] ^ a[7];
  endfunction

  // First requesting master, searching upward from start and wrapping.
  function automatic int pick(input logic [NM-1:0] v, input int start);
    int idx;
    for (int k = 0; k < NM; k++) begin
      idx = (start + k) % NM;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus();
    for (int i = 0; i < NM; i++) begin
      if (!rst && !quiet && !pend[i] && $urandom_range(99) < p_valid) begin
        pend[i]    = 1'b1;
        p_addr[i]  = $urandom;
        p_read[i]  = 1'($urandom);
        p_wdata[i] = $urandom;
        p_wmask[i] = MW'($urandom);
      end
      m_cmd_valid[i]            = pend[i];
      m_cmd_addr[i*AW +: AW]    = pend[i] ? p_addr[i] : '0;
      m_cmd_read[i]             = pend[i] ? p_read[i] : 1'b0;
      m_cmd_wdata[i*DW +: DW]   = pend[i] ? p_wdata[i] : '0;
      m_cmd_wmask[i*MW +: MW]   = pend[i] ? p_wmask[i] : '0;
      m_rsp_ready[i] = !rst && ($urandom_range(99) < p_mready);
    end
    s_cmd_ready = !rst && ($urandom_range(99) < p_sready);
    if (!rst && !sl_valid && slave_q.size() > 0 && $urandom_range(99) < p_rsp)
      sl_valid = 1'b1;
    if (force_unexp) begin
      s_rsp_valid = 1'b1;
      s_rsp_rdata = 32'h0BAD_0BAD;
      s_rsp_err   = 1'b0;
    end else begin
      s_rsp_valid = sl_valid;
      s_rsp_rdata = sl_valid ? rsp_data(slave_q[0]) : '0;
      s_rsp_err   = sl_valid ? rsp_err(slave_q[0]) : 1'b0;
    end
  endtask

  // At the falling edge, compare the DUT with the model, then advance the
  // model and the protocol state of the masters and the memory.
  task automatic evalModel();
    int            gid;
    int            head;
    int            pre_size;
    bit            exp_valid;
    bit            exp_sr;
    logic [NM-1:0] exp_ready;
    logic [NM-1:0] exp_rv;
    if (rst) begin
      mq.delete(); sb.delete(); slave_q.delete();
      sl_valid = 1'b0;
      for (int i = 0; i < NM; i++) pend[i] = 1'b0;
      m_lock = 1'b0; m_lock_id = 0; m_rr = 0; m_err = 1'b0;
      return;
    end
`ifdef CORE_BIU_RR_ARB_EN
    gid = m_lock ? m_lock_id : pick(m_cmd_valid, m_rr);
`else
    gid = m_lock ? m_lock_id : pick(m_cmd_valid, 0);
`endif
    exp_valid = 1'b0;
    if (gid >= 0) exp_valid = m_cmd_valid[gid] && (mq.size() < DEPTH);
    exp_ready = '0;
    if (exp_valid && s_cmd_ready) exp_ready[gid] = 1'b1;
    checkOutput("s_cmd_valid", s_cmd_valid, exp_valid);
    checkOutput("m_cmd_ready", m_cmd_ready, exp_ready);
    if (exp_valid) begin
      checkOutput("s_cmd_addr", s_cmd_addr, p_addr[gid]);
      checkOutput("s_cmd_read", s_cmd_read, p_read[gid]);
      checkOutput("s_cmd_wdata", s_cmd_wdata, p_wdata[gid]);
      checkOutput("s_cmd_wmask", s_cmd_wmask, p_wmask[gid]);
    end
    checkOutput("outs_cnt", outs_cnt, mq.size());
    checkOutput("err_unexp_rsp", err_unexp_rsp, m_err);

    pre_size = mq.size();
    exp_sr = 1'b0;
    exp_rv = '0;
    if (pre_size > 0) begin
      head   = mq[0];
      exp_sr = m_rsp_ready[head];
      if (s_rsp_valid) exp_rv[head] = 1'b1;
    end
    checkOutput("s_rsp_ready", s_rsp_ready, exp_sr);
    checkOutput("m_rsp_valid", m_rsp_valid, exp_rv);
    if (s_rsp_valid) checkOutput("m_rsp_rdata", m_rsp_rdata, s_rsp_rdata);

    if (s_rsp_valid && exp_sr) void'(mq.pop_front());
    if (s_rsp_valid && pre_size == 0) m_err = 1'b1;
    if (exp_valid && s_cmd_ready) begin
      mq.push_back(gid);
      sb.push_back('{gid, rsp_data(p_addr[gid]), rsp_err(p_addr[gid])});
      m_lock = 1'b0;
      m_rr   = (gid + 1) % NM;
    end else if (exp_valid) begin
      m_lock    = 1'b1;
      m_lock_id = gid;
    end else begin
      m_lock = 1'b0;
    end

    for (int i = 0; i < NM; i++)
      if (m_cmd_valid[i] && m_cmd_ready[i]) pend[i] = 1'b0;
    if (s_cmd_valid && s_cmd_ready) slave_q.push_back(s_cmd_addr);
    if (!force_unexp && sl_valid && s_rsp_ready) begin
      void'(slave_q.pop_front());
      sl_valid = 1'b0;
    end
  endtask

  task automatic step(input bit r);
    @(posedge clk);
    #1;
    rst = r;
    applyStimulus();
    @(negedge clk);
    evalModel();
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) step(1'b0);
  endtask

  task automatic setKnobs(input int v, input int sr, input int r, input int mr);
    p_valid = v; p_sready = sr; p_rsp = r; p_mready = mr;
  endtask

  // Monitor: compares each accepted response against the oldest expected one.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NM; i++) begin
        if (m_rsp_valid[i] && m_rsp_ready[i]) begin
          if (sb.size() == 0) begin
            checkOutput("rsp_without_cmd", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("rsp_dest", i, e.id);
            checkOutput("rsp_rdata", m_rsp_rdata, e.rdata);
            checkOutput("rsp_err", m_rsp_err, e.err);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    quiet = 1'b0; force_unexp = 1'b0; sl_valid = 1'b0;
    m_lock = 1'b0; m_lock_id = 0; m_rr = 0; m_err = 1'b0;
    for (int i = 0; i < NM; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_read[i] = 1'b0;
      p_wdata[i] = '0; p_wmask[i] = '0;
    end
    m_cmd_valid = '0; m_cmd_addr = '0; m_cmd_read = '0;
    m_cmd_wdata = '0; m_cmd_wmask = '0; m_rsp_ready = '0;
    s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_rdata = '0; s_rsp_err = 1'b0;
    setKnobs(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) step(1'b1);

    // Idle after reset: every output should be quiet.
    runCycles(2);
    checkOutput("idle_s_cmd_addr", s_cmd_addr, 0);
    checkOutput("idle_m_rsp_rdata", m_rsp_rdata, 0);

    // General mixed traffic.
    setKnobs(50, 70, 60, 70);
    runCycles(400);

    // Fill to OUTS_DEPTH with no responses, then drain.
    setKnobs(90, 100, 0, 100);
    runCycles(40);
    setKnobs(60, 100, 80, 80);
    runCycles(60);

    // Heavy backpressure on both sides exercises the grant lock.
    setKnobs(70, 30, 50, 30);
    runCycles(300);

    // Drain everything, then send a response with nothing outstanding.
    quiet = 1'b1;
    setKnobs(0, 100, 100, 100);
    n = 0;
    while ((mq.size() > 0 || slave_q.size() > 0 || pend[0] || pend[1] || pend[2])
           && n < 300) begin
      step(1'b0);
      n++;
    end
    checkOutput("drain_before_unexp", mq.size(), 0);
    force_unexp = 1'b1;
    step(1'b0);
    force_unexp = 1'b0;
    step(1'b0);
    checkOutput("err_set_after_unexp", err_unexp_rsp, 1);
    quiet = 1'b0;
    setKnobs(50, 70, 60, 70);
    runCycles(100);

    // Reset with transactions outstanding, then traffic resumes.
    setKnobs(80, 100, 0, 100);
    runCycles(20);
    step(1'b1);
    setKnobs(80, 100, 60, 80);
    step(1'b0);
    checkOutput("outs_cnt_after_rst", outs_cnt, 0);
    checkOutput("err_after_rst", err_unexp_rsp, 0);
    runCycles(200);

    // Final drain: every issued command must be answered.
    quiet = 1'b1;
    setKnobs(0, 100, 100, 100);
    n = 0;
    while ((sb.size() > 0 || pend[0] || pend[1] || pend[2]) && n < 500) begin
      step(1'b0);
      n++;
    end
    checkOutput("final_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
